// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard bubbling and a saturating bubble counter.
module id_ex_stage #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_CTRL = 12,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dunit_clk_en,
  input  logic               i_flush,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  input  logic               i_use_rs,
  input  logic               i_use_rt,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]  i_rs_data,
  input  logic [NB_REG-1:0]  i_rt_data,
  input  logic [NB_REG-1:0]  i_imm,
  input  logic [NB_REG-1:0]  i_pc_plus4,
  input  logic               i_mem_read,
  input  logic               i_reg_write,
  input  logic [NB_CTRL-1:0] i_ctrl,
  output logic [NB_REG-1:0]  o_rs_data,
  output logic [NB_REG-1:0]  o_rt_data,
  output logic [NB_REG-1:0]  o_imm,
  output logic [NB_REG-1:0]  o_pc_plus4,
  output logic [NB_ADDR-1:0] o_rs_addr,
  output logic [NB_ADDR-1:0] o_rt_addr,
  output logic [NB_ADDR-1:0] o_wb_addr,
  output logic               o_mem_read,
  output logic               o_reg_write,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic               o_valid,
  output logic               o_stall,
  output logic [NB_CNT-1:0]  o_bubble_cnt
);
  logic hz;
  logic bubble;
  // A load in EX whose target is read by the ID instruction; $0 never conflicts.
  assign hz = o_valid & o_mem_read & (o_wb_addr != '0) &
              ((i_use_rs & (i_rs_addr == o_wb_addr)) | (i_use_rt & (i_rt_addr == o_wb_addr)));
  assign bubble  = i_flush | hz;
  assign o_stall = hz & ~i_flush;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rs_data    <= '0;
      o_rt_data    <= '0;
      o_imm        <= '0;
      o_pc_plus4   <= '0;
      o_rs_addr    <= '0;
      o_rt_addr    <= '0;
      o_wb_addr    <= '0;
      o_mem_read   <= 1'b0;
      o_reg_write  <= 1'b0;
      o_ctrl       <= '0;
      o_valid      <= 1'b0;
      o_bubble_cnt <= '0;
    end else if (i_dunit_clk_en) begin
      o_rs_data    <= bubble ? '0 : i_rs_data;
      o_rt_data    <= bubble ? '0 : i_rt_data;
      o_imm        <= bubble ? '0 : i_imm;
      o_pc_plus4   <= bubble ? '0 : i_pc_plus4;
      o_rs_addr    <= bubble ? '0 : i_rs_addr;
      o_rt_addr    <= bubble ? '0 : i_rt_addr;
      o_wb_addr    <= bubble ? '0 : i_wb_addr;
      o_mem_read   <= bubble ? 1'b0 : i_mem_read;
      o_reg_write  <= bubble ? 1'b0 : i_reg_write;
      o_ctrl       <= bubble ? '0 : i_ctrl;
      o_valid      <= ~bubble;
      o_bubble_cnt <= (bubble & ~&o_bubble_cnt) ? o_bubble_cnt + NB_CNT'(1) : o_bubble_cnt;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of loading, load-use bubbling, flush, debug freeze and counter saturation.
module tb_id_ex_stage;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1, flush = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wb_addr = '0;
  logic        use_rs = 1'b0, use_rt = 1'b0, mem_read = 1'b0, reg_write = 1'b0;
  logic [31:0] rs_data = '0, rt_data = '0, imm = '0, pc = '0;
  logic [11:0] ctrl = '0;
  logic [31:0] q_rs_data, q_rt_data, q_imm, q_pc;
  logic [4:0]  q_rs_addr, q_rt_addr, q_wb_addr;
  logic        q_mem_read, q_reg_write, q_valid, q_stall;
  logic [11:0] q_ctrl;
  logic [3:0]  q_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  id_ex_stage #(.NB_CNT(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_dunit_clk_en(en), .i_flush(flush),
    .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .i_use_rs(use_rs), .i_use_rt(use_rt),
    .i_wb_addr(wb_addr), .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm),
    .i_pc_plus4(pc), .i_mem_read(mem_read), .i_reg_write(reg_write), .i_ctrl(ctrl),
    .o_rs_data(q_rs_data), .o_rt_data(q_rt_data), .o_imm(q_imm), .o_pc_plus4(q_pc),
    .o_rs_addr(q_rs_addr), .o_rt_addr(q_rt_addr), .o_wb_addr(q_wb_addr),
    .o_mem_read(q_mem_read), .o_reg_write(q_reg_write), .o_ctrl(q_ctrl),
    .o_valid(q_valid), .o_stall(q_stall), .o_bubble_cnt(q_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    check("rst_valid", 32'(q_valid), 0);
    check("rst_cnt", 32'(q_cnt), 0);
    check("rst_stall", 32'(q_stall), 0);
    rst = 1'b0;
    rs_data = 32'h1234; rt_data = 32'h55; imm = 32'h7; pc = 32'h100;
    wb_addr = 5'd3; reg_write = 1'b1; ctrl = 12'hABC;
    step();
    check("load_rs_data", q_rs_data, 32'h1234);
    check("load_valid", 32'(q_valid), 1);
    check("load_ctrl", 32'(q_ctrl), 32'hABC);
    check("load_wb", 32'(q_wb_addr), 3);
    check("load_pc", q_pc, 32'h100);
    // Asynchronous reset mid-cycle with state loaded
    #2 rst = 1'b1;
    #1;
    check("arst_rs_data", q_rs_data, 0);
    check("arst_valid", 32'(q_valid), 0);
    check("arst_ctrl", 32'(q_ctrl), 0);
    #1 rst = 1'b0;
    step();
    check("rel_rs_data", q_rs_data, 32'h1234);
    check("rel_valid", 32'(q_valid), 1);
    // Load-use on rs
    mem_read = 1'b1; wb_addr = 5'd5; ctrl = 12'h111;
    step();
    check("ld_mem_read", 32'(q_mem_read), 1);
    mem_read = 1'b0; wb_addr = 5'd6; rs_addr = 5'd5; use_rs = 1'b1; rs_data = 32'hAAAA; ctrl = 12'h222;
    #1;
    check("hz_stall", 32'(q_stall), 1);
    step();
    check("bub_valid", 32'(q_valid), 0);
    check("bub_ctrl", 32'(q_ctrl), 0);
    check("bub_rs_data", q_rs_data, 0);
    check("bub_cnt", 32'(q_cnt), 1);
    check("bub_stall", 32'(q_stall), 0);
    step();
    check("after_valid", 32'(q_valid), 1);
    check("after_rs_data", q_rs_data, 32'hAAAA);
    check("after_ctrl", 32'(q_ctrl), 32'h222);
    // No hazard when operand not used, hazard via rt
    mem_read = 1'b1; wb_addr = 5'd5; use_rs = 1'b0;
    step();
    mem_read = 1'b0; rs_addr = 5'd5; rt_addr = 5'd5; use_rs = 1'b0; use_rt = 1'b0;
    #1;
    check("nouse_stall", 32'(q_stall), 0);
    use_rt = 1'b1;
    #1;
    check("rt_stall", 32'(q_stall), 1);
    use_rt = 1'b0;
    step();
    check("nouse_valid", 32'(q_valid), 1);
    check("nouse_cnt", 32'(q_cnt), 1);
    // Load to $0 never hazards
    mem_read = 1'b1; wb_addr = 5'd0;
    step();
    mem_read = 1'b0; rs_addr = 5'd0; use_rs = 1'b1;
    #1;
    check("r0_stall", 32'(q_stall), 0);
    step();
    check("r0_valid", 32'(q_valid), 1);
    check("r0_cnt", 32'(q_cnt), 1);
    // Hazard coincident with flush: single bubble, no stall
    mem_read = 1'b1; wb_addr = 5'd7; use_rs = 1'b0;
    step();
    mem_read = 1'b0; rs_addr = 5'd7; use_rs = 1'b1; flush = 1'b1;
    #1;
    check("hzfl_stall", 32'(q_stall), 0);
    step();
    flush = 1'b0;
    check("hzfl_valid", 32'(q_valid), 0);
    check("hzfl_cnt", 32'(q_cnt), 2);
    // Debug freeze with hazard pending
    use_rs = 1'b0; mem_read = 1'b1; wb_addr = 5'd9; rs_data = 32'h42;
    step();
    en = 1'b0; mem_read = 1'b0; rs_addr = 5'd9; use_rs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'h90 + 32'(i); ctrl = 12'(i + 1);
      step();
      check("frz_rs_data", q_rs_data, 32'h42);
      check("frz_cnt", 32'(q_cnt), 2);
      check("frz_stall", 32'(q_stall), 1);
    end
    use_rs = 1'b0; en = 1'b1;
    step();
    check("unfrz_rs_data", q_rs_data, 32'h92);
    check("unfrz_ctrl", 32'(q_ctrl), 3);
    check("unfrz_cnt", 32'(q_cnt), 2);
    // Pending hazard across freeze is applied on re-enable
    mem_read = 1'b1; wb_addr = 5'd4;
    step();
    en = 1'b0; mem_read = 1'b0; rt_addr = 5'd4; use_rt = 1'b1;
    step();
    check("pend_stall", 32'(q_stall), 1);
    en = 1'b1;
    step();
    check("pend_valid", 32'(q_valid), 0);
    check("pend_cnt", 32'(q_cnt), 3);
    use_rt = 1'b0;
    // Saturation of the 4-bit counter
    flush = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("sat_reach", 32'(q_cnt), 15);
    for (int i = 0; i < 4; i++) step();
    check("sat_hold", 32'(q_cnt), 15);
    flush = 1'b0;
    // Reset mid-stall
    mem_read = 1'b1; wb_addr = 5'd8;
    step();
    mem_read = 1'b0; rs_addr = 5'd8; use_rs = 1'b1;
    #1;
    check("ms_stall_pre", 32'(q_stall), 1);
    rst = 1'b1;
    #1;
    check("ms_stall", 32'(q_stall), 0);
    check("ms_cnt", 32'(q_cnt), 0);
    check("ms_valid", 32'(q_valid), 0);
    #1 rst = 1'b0;
    rs_data = 32'h77;
    step();
    check("ms_resume", q_rs_data, 32'h77);
    check("ms_resume_valid", 32'(q_valid), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
